// File: rtl/dnn_output_eval.sv
// Output evaluation stage: reassembles serially delivered ideal-output chunks,
// compares them with the network output, and accumulates windowed accuracy.
module dnn_output_eval #(
  parameter int NOUT      = 16,
  parameter int NOUT_USED = 10,
  parameter int ANS_W     = 1,
  parameter int CPC       = 18,
  parameter int WIN       = 1000,
  parameter int SKIP      = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [$clog2(CPC)-1:0]     cycle_index,
  input  logic [ANS_W-1:0]           ansL,
  input  logic [NOUT-1:0]            actL_alln,
  output logic                       eval_valid,
  output logic                       eval_correct,
  output logic                       acc_valid,
  output logic [$clog2(WIN+1)-1:0]   acc_count,
  output logic [31:0]                cases_total
);
  localparam int CIW = $clog2(CPC);
  localparam int AW  = $clog2(WIN+1);
  localparam int G   = NOUT / ANS_W;
  localparam int SKW = (SKIP > 0) ? $clog2(SKIP+1) : 1;
  localparam int WW  = (WIN > 1) ? $clog2(WIN) : 1;
  localparam logic [CIW-1:0] LAST_C   = CIW'(CPC-1);
  localparam logic [SKW-1:0] SKIP_V   = SKW'(SKIP);
  localparam logic [WW-1:0]  WIN_LAST = WW'(WIN-1);

  logic [NOUT-1:0] ideal_q, ideal_d;
  logic [SKW-1:0]  skip_q, skip_d;
  logic [WW-1:0]   win_q, win_d;
  logic [AW-1:0]   corr_q, corr_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [31:0]     tot_q, tot_d;
  logic            ev_q, ec_q, av_q;
  logic            ev_d, ec_d, av_d;
  logic            eval_now, counted, match, last;
  int              ci, cap_g;

  // Chunk g arrives at cycle (g+2) mod G, so cycle c lands in chunk (c-2) mod G.
  always_comb begin
    ideal_d = ideal_q;
    ci      = int'(cycle_index);
    cap_g   = 0;
    if (ci < G) begin
      cap_g = (ci + 2*G - 2) % G;
      for (int k = 0; k < G; k++)
        if (k == cap_g) ideal_d[k*ANS_W +: ANS_W] = ansL;
    end
  end

  assign eval_now = en && (cycle_index == LAST_C);
  assign match    = (ideal_q[NOUT_USED-1:0] == actL_alln[NOUT_USED-1:0]);
  assign counted  = eval_now && (skip_q == SKIP_V);
  assign last     = (win_q == WIN_LAST);

  always_comb begin
    skip_d = skip_q;
    win_d  = win_q;
    corr_d = corr_q;
    acc_d  = acc_q;
    tot_d  = tot_q;
    ev_d   = counted;
    ec_d   = counted && match;
    av_d   = counted && last;
    if (eval_now && skip_q != SKIP_V)
      skip_d = skip_q + 1'b1;
    if (counted) begin
      if (tot_q != 32'hFFFF_FFFF) tot_d = tot_q + 32'd1;
      if (last) begin
        acc_d  = corr_q + AW'(match);
        win_d  = '0;
        corr_d = '0;
      end else begin
        win_d  = win_q + 1'b1;
        corr_d = corr_q + AW'(match);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ideal_q <= '0;
      skip_q  <= '0;
      win_q   <= '0;
      corr_q  <= '0;
      acc_q   <= '0;
      tot_q   <= '0;
      ev_q    <= 1'b0;
      ec_q    <= 1'b0;
      av_q    <= 1'b0;
    end else begin
      ideal_q <= ideal_d;
      skip_q  <= skip_d;
      win_q   <= win_d;
      corr_q  <= corr_d;
      acc_q   <= acc_d;
      tot_q   <= tot_d;
      ev_q    <= ev_d;
      ec_q    <= ec_d;
      av_q    <= av_d;
    end
  end

  assign eval_valid   = ev_q;
  assign eval_correct = ec_q;
  assign acc_valid    = av_q;
  assign acc_count    = acc_q;
  assign cases_total  = tot_q;
endmodule

// File: tb/tb_dnn_output_eval.sv
// Directed bench for dnn_output_eval (NOUT=16, NOUT_USED=10, ANS_W=1, CPC=18, WIN=4, SKIP=1).
module tb_dnn_output_eval;
  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [4:0]  cycle_index;
  logic [0:0]  ansL;
  logic [15:0] actL_alln;
  logic        eval_valid, eval_correct, acc_valid;
  logic [2:0]  acc_count;
  logic [31:0] cases_total;
  int          n_assert = 0;
  int          n_fail   = 0;

  dnn_output_eval #(.NOUT(16), .NOUT_USED(10), .ANS_W(1), .CPC(18), .WIN(4), .SKIP(1)) dut (
    .clk(clk), .reset(reset), .en(en), .cycle_index(cycle_index), .ansL(ansL),
    .actL_alln(actL_alln), .eval_valid(eval_valid), .eval_correct(eval_correct),
    .acc_valid(acc_valid), .acc_count(acc_count), .cases_total(cases_total)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic ec, input logic av,
                         input logic [2:0] ac, input logic [31:0] tot);
    chk({tag, ".eval_valid"},   32'(eval_valid),   32'(ev));
    chk({tag, ".eval_correct"}, 32'(eval_correct), 32'(ec));
    chk({tag, ".acc_valid"},    32'(acc_valid),    32'(av));
    chk({tag, ".acc_count"},    32'(acc_count),    32'(ac));
    chk({tag, ".cases_total"},  cases_total,       tot);
  endtask

  // One block cycle, entered and left at a falling edge. en_mode: 0 off, 1 on, 2 only at c=17.
  // Chunks for c>=16 are driven to 1 and must not be captured.
  task automatic run_block(input string tag, input logic [15:0] ideal, input logic [15:0] act,
                           input int en_mode, input int rst_at,
                           input logic ev, input logic ec, input logic av,
                           input logic [2:0] ac, input logic [31:0] tot);
    for (int c = 0; c < 18; c++) begin
      cycle_index = 5'(c);
      ansL        = (c < 16) ? ideal[(c + 14) % 16] : 1'b1;
      actL_alln   = act;
      en          = (en_mode == 1) || (en_mode == 2 && c == 17);
      if (c == rst_at) begin
        #1 reset = 1'b0;
        #1 chk_out({tag, ".async_rst"}, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
      end
      @(negedge clk);
      if (c == 0) begin
        chk({tag, ".pulse_end_ev"}, 32'(eval_valid), 32'd0);
        chk({tag, ".pulse_end_av"}, 32'(acc_valid),  32'd0);
      end
    end
    chk_out(tag, ev, ec, av, ac, tot);
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; cycle_index = '0; ansL = '0; actL_alln = '0;
    repeat (2) @(negedge clk);
    chk_out("reset", 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    reset = 1'b1;

    run_block("skip",     16'h0001, 16'h0001, 1, -1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    run_block("w1c1",     16'h0001, 16'h0001, 1, -1, 1'b1, 1'b1, 1'b0, 3'd0, 32'd1);
    run_block("w1c2",     16'h0001, 16'h0003, 1, -1, 1'b1, 1'b0, 1'b0, 3'd0, 32'd2);
    run_block("w1c3",     16'h0001, 16'hFC01, 1, -1, 1'b1, 1'b1, 1'b0, 3'd0, 32'd3);
    run_block("w1c4",     16'h02A5, 16'h02A5, 1, -1, 1'b1, 1'b1, 1'b1, 3'd3, 32'd4);
    run_block("w2c1",     16'h0155, 16'h0154, 1, -1, 1'b1, 1'b0, 1'b0, 3'd3, 32'd5);
    run_block("w2c2",     16'h03FF, 16'h01FF, 1, -1, 1'b1, 1'b0, 1'b0, 3'd3, 32'd6);
    run_block("w2c3",     16'h0200, 16'h0000, 1, -1, 1'b1, 1'b0, 1'b0, 3'd3, 32'd7);
    run_block("w2c4",     16'h0000, 16'h0001, 1, -1, 1'b1, 1'b0, 1'b1, 3'd0, 32'd8);
    run_block("en_off1",  16'h0123, 16'h0123, 0, -1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd8);
    run_block("en_off2",  16'h0123, 16'h0123, 0, -1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd8);
    run_block("en_last",  16'h0123, 16'h0123, 2, -1, 1'b1, 1'b1, 1'b0, 3'd0, 32'd9);
    run_block("w3c2",     16'h03C3, 16'h03C3, 1, -1, 1'b1, 1'b1, 1'b0, 3'd0, 32'd10);
    run_block("w3c3_rst", 16'h0001, 16'h0001, 1,  9, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    reset = 1'b1;
    run_block("rst_skip", 16'h0001, 16'h0001, 1, -1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    run_block("w4c1",     16'h0011, 16'h0011, 1, -1, 1'b1, 1'b1, 1'b0, 3'd0, 32'd1);
    run_block("w4c2",     16'h0222, 16'h8222, 1, -1, 1'b1, 1'b1, 1'b0, 3'd0, 32'd2);
    run_block("w4c3",     16'h0333, 16'h0333, 1, -1, 1'b1, 1'b1, 1'b0, 3'd0, 32'd3);
    run_block("w4c4",     16'h0044, 16'h0044, 1, -1, 1'b1, 1'b1, 1'b1, 3'd4, 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/dnn_output_eval.md
# dnn_output_eval

Output evaluation stage placed directly downstream of the DNN top level. Each block cycle it reassembles the serially delivered ideal-output chunks (`ansL`) into a full ideal vector and compares it with the network's all-neuron 1-bit output (`actL_alln`). It then accumulates per-case correctness into windowed accuracy counts and a saturating total, for on-chip training monitoring.

## Interface
Parameters:
- `NOUT`, 16: output neurons (n[L-1]); width of `actL_alln`.
- `NOUT_USED`, 10: neurons that carry real labels; bits [NOUT-1:NOUT_USED] are ignored in comparison.
- `ANS_W`, 1: ideal-output bits delivered per clock (z[L-2]/fi[L-2]); must divide `NOUT`.
- `CPC`, 18: clocks per block cycle; requires CPC ≥ NOUT/ANS_W + 1.
- `WIN`, 1000: evaluated cases per accuracy window.
- `SKIP`, 2: evaluations discarded after reset (pipeline warm-up).

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-low reset.
- `en`  in  1  evaluation enable; sampled at the evaluation cycle.
- `cycle_index`  in  $clog2(CPC)  position within block cycle (0..CPC-1).
- `ansL`  in  ANS_W  ideal-output chunk for the current cycle.
- `actL_alln`  in  NOUT  network output, all neurons.
- `eval_valid`  out  1  one-clock pulse per evaluated case.
- `eval_correct`  out  1  result of that case; meaningful when `eval_valid`=1.
- `acc_valid`  out  1  one-clock pulse at window completion.
- `acc_count`  out  $clog2(WIN+1)  correct cases in the last completed window; held.
- `cases_total`  out  32  evaluated cases since reset, saturating at 2^32-1.

## Operation
- G = NOUT/ANS_W chunks per case.
- Capture: on each clock with cycle_index = c < G, write `ansL` into chunk g = (c − 2) mod G of the ideal register, bits [g·ANS_W +: ANS_W]. Example: c=0 → g=G−2, c=1 → g=G−1, c=2 → g=0. For c ≥ G, no capture.
- Evaluate: on a clock with cycle_index = CPC−1 and en=1, compute match = (ideal[NOUT_USED-1:0] == actL_alln[NOUT_USED-1:0]).
  - If the skip counter is below SKIP, increment it and produce no other effect.
  - Otherwise register the result into `eval_valid`/`eval_correct`.
- With en=0 at cycle CPC−1, no evaluation occurs and nothing increments. Capture continues regardless of en.
- Window state:
  - win_cnt counts 0..WIN−1 and corr_cnt accumulates correct cases.
  - On the WIN-th evaluation, `acc_count` ← corr_cnt + match, `acc_valid` pulses, and win_cnt and corr_cnt clear to 0 in the same clock.
  - `acc_count` holds its value until the next window completes.
- `cases_total` increments per counted evaluation and saturates (no wrap).
- cycle_index jumps or repeats are not checked. Capture and evaluation act purely on the current value.
- Internal state consists of the ideal register, skip counter, win_cnt, corr_cnt and cases_total. There is no FSM beyond the skip phase and the count phase, where skip counter = SKIP marks the count phase.

## Timing
- Reset (reset=0, asynchronous) clears immediately: all outputs 0, ideal register 0, skip counter 0, win_cnt 0, corr_cnt 0. Reset mid-window discards the partial window and restarts the skip phase.
- Capture latency: chunk written at the rising edge of the capture clock.
- Evaluation compares against the ideal register as of the start of the CPC−1 clock.
- `eval_valid`/`eval_correct` assert 1 clock after the CPC−1 clock and last one clock.
- `acc_valid` is coincident with the `eval_valid` of the window's last case. `acc_count` updates at the same edge.
- SKIP=0 means the first evaluation counts. WIN=1 means every evaluation completes a window.

## Test plan
(NOUT=16, NOUT_USED=10, ANS_W=1, CPC=18, WIN=4, SKIP=1.)
- Reset then run one block with ansL=1 at c=2 only, actL_alln=16'h0001 → no eval_valid pulse (skipped); cases_total=0.
- Next block: same stimulus → eval_valid=1, eval_correct=1 at the clock after c=17; cases_total=1.
- Ideal 10'h001 vs actL_alln=16'h0003 → eval_correct=0. Ideal 10'h001 vs actL_alln=16'hFC01 (bits 10–15 differ only) → eval_correct=1.
- Four counted cases with pattern correct, wrong, correct, correct → acc_valid pulse coincident with the 4th eval_valid, acc_count=3. The next window with all wrong → acc_count=0; acc_count holds 3 in between.
- Hold en=0 across two blocks → no eval_valid pulses and counters unchanged. Capture still occurs: verify by setting en=1 at c=17 only, giving a correct result.
- Assert reset at c=9 of the 3rd case in a window → outputs 0 immediately. After release, the first evaluation is skipped and the next window needs 4 fresh cases.
